// File: rtl/picorv32_wb_master_if.sv
// Bus bundle for picorv32_wb_master: picorv32 native memory port plus pipelined Wishbone B4 master.
// The master modport is the bridge's view; the slave modport is the CPU/interconnect side.
interface picorv32_wb_master_if;
  logic        i_mem_valid;
  logic        i_mem_instr;
  logic [31:0] i_mem_addr;
  logic [31:0] i_mem_wdata;
  logic [3:0]  i_mem_wstrb;
  logic        o_mem_ready;
  logic [31:0] o_mem_rdata;

  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [31:0] o_wb_addr;
  logic [31:0] o_wb_data;
  logic [3:0]  o_wb_sel;
  logic        i_wb_ack;
  logic [31:0] i_wb_data;
  logic        i_wb_stall;
  logic        i_wb_err;

  modport master (
    input  i_mem_valid, i_mem_instr, i_mem_addr, i_mem_wdata, i_mem_wstrb,
    output o_mem_ready, o_mem_rdata,
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
    input  i_wb_ack, i_wb_data, i_wb_stall, i_wb_err
  );

  modport slave (
    output i_mem_valid, i_mem_instr, i_mem_addr, i_mem_wdata, i_mem_wstrb,
    input  o_mem_ready, o_mem_rdata,
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
    output i_wb_ack, i_wb_data, i_wb_stall, i_wb_err
  );
endinterface

// File: rtl/picorv32_wb_master.sv
// picorv32 native memory -> single-beat pipelined Wishbone B4 master, all outputs registered.
// Optional bus watchdog enabled by defining WB_MASTER_TIMEOUT_EN.
module picorv32_wb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  picorv32_wb_master_if.master        bus,
  output logic                        o_bus_err,
  output logic [31:0]                 o_bus_err_addr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_cyc,      w_cyc_nxt;
  logic        r_stb,      w_stb_nxt;
  logic        r_we,       w_we_nxt;
  logic [31:0] r_addr,     w_addr_nxt;
  logic [31:0] r_data,     w_data_nxt;
  logic [3:0]  r_sel,      w_sel_nxt;
  logic        r_ready,    w_ready_nxt;
  logic [31:0] r_rdata,    w_rdata_nxt;
  logic        r_err,      w_err_nxt;
  logic [31:0] r_err_addr, w_err_addr_nxt;

  logic        w_timeout;
  logic        w_fail;
  logic        w_unused_instr;

  assign w_unused_instr = bus.i_mem_instr;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_tmo_cnt;

  // Counter value k means cyc has been high for k+1 cycles, so the abort edge lands on cycle TIMEOUT_CYCLES.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_IDLE && w_state_nxt == S_REQ) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_REQ || r_state == S_WAIT) begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end

  assign w_timeout = (r_tmo_cnt == TMO_LAST);
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
  assign w_timeout    = 1'b0;
`endif

  // Error beats ack; ack beats a timeout on the same cycle.
  assign w_fail = bus.i_wb_err || (w_timeout && !bus.i_wb_ack);

  always_comb begin
    w_state_nxt    = r_state;
    w_cyc_nxt      = r_cyc;
    w_stb_nxt      = r_stb;
    w_we_nxt       = r_we;
    w_addr_nxt     = r_addr;
    w_data_nxt     = r_data;
    w_sel_nxt      = r_sel;
    w_ready_nxt    = 1'b0;
    w_rdata_nxt    = r_rdata;
    w_err_nxt      = 1'b0;
    w_err_addr_nxt = r_err_addr;

    case (r_state)
      S_IDLE: begin
        if (bus.i_mem_valid) begin
          w_addr_nxt  = bus.i_mem_addr;
          w_data_nxt  = bus.i_mem_wdata;
          w_we_nxt    = |bus.i_mem_wstrb;
          w_sel_nxt   = (|bus.i_mem_wstrb) ? bus.i_mem_wstrb : 4'hF;
          w_cyc_nxt   = 1'b1;
          w_stb_nxt   = 1'b1;
          w_state_nxt = S_REQ;
        end
      end

      S_REQ, S_WAIT: begin
        if (w_fail) begin
          w_cyc_nxt      = 1'b0;
          w_stb_nxt      = 1'b0;
          w_ready_nxt    = 1'b1;
          w_err_nxt      = 1'b1;
          w_err_addr_nxt = r_addr;
          if (!r_we) begin
            w_rdata_nxt = ERR_RDATA;
          end
          w_state_nxt    = S_DONE;
        end else if (bus.i_wb_ack) begin
          w_cyc_nxt   = 1'b0;
          w_stb_nxt   = 1'b0;
          w_ready_nxt = 1'b1;
          if (!r_we) begin
            w_rdata_nxt = bus.i_wb_data;
          end
          w_state_nxt = S_DONE;
        end else if (r_state == S_REQ && !bus.i_wb_stall) begin
          w_stb_nxt   = 1'b0;
          w_state_nxt = S_WAIT;
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_cyc      <= 1'b0;
      r_stb      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_sel      <= '0;
      r_ready    <= 1'b0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cyc      <= w_cyc_nxt;
      r_stb      <= w_stb_nxt;
      r_we       <= w_we_nxt;
      r_addr     <= w_addr_nxt;
      r_data     <= w_data_nxt;
      r_sel      <= w_sel_nxt;
      r_ready    <= w_ready_nxt;
      r_rdata    <= w_rdata_nxt;
      r_err      <= w_err_nxt;
      r_err_addr <= w_err_addr_nxt;
    end
  end

  assign bus.o_wb_cyc    = r_cyc;
  assign bus.o_wb_stb    = r_stb;
  assign bus.o_wb_we     = r_we;
  assign bus.o_wb_addr   = r_addr;
  assign bus.o_wb_data   = r_data;
  assign bus.o_wb_sel    = r_sel;
  assign bus.o_mem_ready = r_ready;
  assign bus.o_mem_rdata = r_rdata;
  assign o_bus_err       = r_err;
  assign o_bus_err_addr  = r_err_addr;

endmodule
